// File: rtl/perf_pkg.sv
// Shared index map and helpers for the performance-counter bank.
package perf_pkg;

  localparam int BR_TOTAL_OFS     = 0;
  localparam int BR_CORRECT_OFS   = 1;
  localparam int BR_INCORRECT_OFS = 2;

  typedef logic [7:0] perf_idx_t;

  function automatic int num_cnt(input int num_ev);
    return num_ev + 3;
  endfunction

endpackage

// File: rtl/perf_monitor_bank_if.sv
// Control/event inputs and read-back outputs of the performance-counter bank.
interface perf_monitor_bank_if
  import perf_pkg::*;
#(
  parameter int NUM_EV = 4,
  parameter int CNT_W  = 32
) ();

  localparam int NUM_CNT = num_cnt(NUM_EV);
  localparam int SEL_W   = $clog2(NUM_CNT);

  logic              stall;
  logic              clear;
  logic [NUM_EV-1:0] ev_i;
  logic              pred_i;
  logic              br_valid;
  logic              br_taken;
  logic              snap;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CNT-1:0] ovf;

  modport master (
    output stall, clear, ev_i, pred_i, br_valid, br_taken, snap, rd_sel,
    input  rd_data, ovf
  );

  modport slave (
    input  stall, clear, ev_i, pred_i, br_valid, br_taken, snap, rd_sel,
    output rd_data, ovf
  );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with clear, sticky overflow and optional saturation.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    if (c != ALL_ONES) return c + CNT_W'(1);
    return (SATURATE != 0) ? ALL_ONES : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      count <= bump(count);
      if (count == ALL_ONES) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_monitor_bank.sv
// Performance-counter bank: generic events plus stall-aware branch statistics.
// Optional snapshot shadow bank enabled by defining PERF_SNAPSHOT_EN.
module perf_monitor_bank
  import perf_pkg::*;
#(
  parameter int NUM_EV     = 4,
  parameter int CNT_W      = 32,
  parameter int PRED_DELAY = 2,
  parameter int SATURATE   = 0
) (
  input logic               clk,
  input logic               rst,
  perf_monitor_bank_if.slave bus
);

  localparam int NUM_CNT = num_cnt(NUM_EV);
  localparam int SEL_W   = $clog2(NUM_CNT);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic                pred_d;
  logic [NUM_CNT-1:0]  inc;
  logic [CNT_W-1:0]    cnt    [NUM_CNT];
  logic [CNT_W-1:0]    src    [NUM_CNT];
  logic [CNT_W-1:0]    rd_src [2**SEL_W];
  logic [NUM_CNT-1:0]  ovf_v;

  // Prediction delay line: fetch-stage prediction aligned to resolve stage
  if (PRED_DELAY == 0) begin : g_nodly
    assign pred_d = bus.pred_i;
  end else begin : g_dly
    logic [PRED_DELAY-1:0] pred_p0;
    always_ff @(posedge clk) begin
      if (rst) begin
        pred_p0 <= '0;
      end else if (!bus.stall) begin
        pred_p0[0] <= bus.pred_i;
        for (int i = 1; i < PRED_DELAY; i++) pred_p0[i] <= pred_p0[i-1];
      end
    end
    assign pred_d = pred_p0[PRED_DELAY-1];
  end

  always_comb begin
    inc = '0;
    if (!bus.stall) begin
      inc[NUM_EV-1:0]                = bus.ev_i;
      inc[NUM_EV + BR_TOTAL_OFS]     = bus.br_valid;
      inc[NUM_EV + BR_CORRECT_OFS]   = bus.br_valid && (bus.br_taken == pred_d);
      inc[NUM_EV + BR_INCORRECT_OFS] = bus.br_valid && (bus.br_taken != pred_d);
    end
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_counter #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.clear),
      .inc   (inc[k]),
      .count (cnt[k]),
      .ovf   (ovf_v[k])
    );
  end

  assign bus.ovf = ovf_v;

`ifdef PERF_SNAPSHOT_EN
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
    if (c != ALL_ONES) return c + CNT_W'(1);
    return (SATURATE != 0) ? ALL_ONES : '0;
  endfunction

  logic [CNT_W-1:0] shadow [NUM_CNT];

  // Shadow captures the post-edge value, so a same-cycle increment is included
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CNT; k++) shadow[k] <= '0;
    end else if (bus.snap) begin
      for (int k = 0; k < NUM_CNT; k++)
        shadow[k] <= bus.clear ? '0 : (inc[k] ? bump(cnt[k]) : cnt[k]);
    end
  end

  assign src = shadow;
`else
  logic unused_snap;
  logic [CNT_W-1:0] unused_ones;
  assign unused_snap = bus.snap;
  assign unused_ones = ALL_ONES;
  assign src = cnt;
`endif

  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_rd
    if (k < NUM_CNT) begin : g_live
      assign rd_src[k] = src[k];
    end else begin : g_zero
      assign rd_src[k] = '0;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst) bus.rd_data <= '0;
    else     bus.rd_data <= rd_src[bus.rd_sel];
  end

endmodule

// File: tb/tb_perf_monitor_bank.sv
// Scoreboard bench: a wrapping and a saturating 4-bit bank driven in lockstep.
`timescale 1ns/1ps
module tb_perf_monitor_bank;
  import perf_pkg::*;

  localparam int NUM_EV  = 4;
  localparam int CNT_W   = 4;
  localparam int NUM_CNT = num_cnt(NUM_EV);
  localparam int SEL_W   = $clog2(NUM_CNT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              stall, clear, pred, brv, brt, snap, rd_req;
  logic [NUM_EV-1:0] ev;
  logic [SEL_W-1:0]  rd_sel;

  perf_monitor_bank_if #(.NUM_EV(NUM_EV), .CNT_W(CNT_W)) bw ();
  perf_monitor_bank_if #(.NUM_EV(NUM_EV), .CNT_W(CNT_W)) bs ();

  assign bw.stall = stall;  assign bs.stall = stall;
  assign bw.clear = clear;  assign bs.clear = clear;
  assign bw.ev_i  = ev;     assign bs.ev_i  = ev;
  assign bw.pred_i = pred;  assign bs.pred_i = pred;
  assign bw.br_valid = brv; assign bs.br_valid = brv;
  assign bw.br_taken = brt; assign bs.br_taken = brt;
  assign bw.snap = snap;    assign bs.snap = snap;
  assign bw.rd_sel = rd_sel; assign bs.rd_sel = rd_sel;

  perf_monitor_bank #(.NUM_EV(NUM_EV), .CNT_W(CNT_W), .PRED_DELAY(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bw.slave));
  perf_monitor_bank #(.NUM_EV(NUM_EV), .CNT_W(CNT_W), .PRED_DELAY(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .bus(bs.slave));

  typedef struct {
    logic [CNT_W-1:0]   ew, es;
    logic [NUM_CNT-1:0] ow, os;
    string              name;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_CNT-1:0] exp_ovf_w = '0, exp_ovf_s = '0;
  bit auto_snap = 1'b1;
  bit rd_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sbq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_underrun: got read with no expectation, required queued entry");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.name, "_wrap"},     32'(bw.rd_data), 32'(e.ew));
        chk({e.name, "_sat"},      32'(bs.rd_data), 32'(e.es));
        chk({e.name, "_ovf_wrap"}, 32'(bw.ovf),     32'(e.ow));
        chk({e.name, "_ovf_sat"},  32'(bs.ovf),     32'(e.os));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input int sel, input int ew, input int es, input string nm);
    exp_t e;
`ifdef PERF_SNAPSHOT_EN
    if (auto_snap) begin snap = 1'b1; tick(); snap = 1'b0; end
`endif
    e.ew = CNT_W'(ew); e.es = CNT_W'(es);
    e.ow = exp_ovf_w;  e.os = exp_ovf_s;
    e.name = nm;
    rd_sel = SEL_W'(sel);
    rd_req = 1'b1;
    sbq.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 0; clear = 0; pred = 0; brv = 0; brt = 0; snap = 0;
    rd_req = 0; ev = '0; rd_sel = '0;
    // reset state, including out-of-range select
    tick(); tick();
    rst = 1'b0;
    for (int s = 0; s < 8; s++) rd(s, 0, 0, $sformatf("reset_sel%0d", s));

    // ev1 for 5 unstalled cycles
    ev = 4'b0010;
    repeat (5) tick();
    ev = '0;
    rd(1, 5, 5, "ev1_count5");

    // branch alignment through the 2-deep delay line
    pred = 1; tick();
    pred = 0; tick();
    pred = 1; brv = 1; brt = 1; tick();
    pred = 0; brv = 1; brt = 0; tick();
    pred = 0; brv = 1; brt = 0; tick();
    brv = 0;
    rd(4, 3, 3, "br_total");
    rd(5, 2, 2, "br_correct");
    rd(6, 1, 1, "br_incorrect");

    // stall freezes counters and the delay line
    pred = 1; tick();
    pred = 0; tick();
    stall = 1; ev = 4'b0001; brv = 1; brt = 1;
    for (int i = 0; i < 4; i++) begin pred = i[0]; tick(); end
    ev = '0; brv = 0; pred = 0;
    rd(0, 0, 0, "stall_ev0");
    rd(4, 3, 3, "stall_total");
    stall = 0;
    brv = 1; brt = 1; tick();
    brv = 1; brt = 0; tick();
    brv = 0;
    rd(4, 5, 5, "post_stall_total");
    rd(5, 4, 4, "post_stall_correct");
    rd(6, 1, 1, "post_stall_incorrect");

    // 17 increments: wrap vs saturate
    ev = 4'b0001;
    repeat (17) tick();
    ev = '0;
    exp_ovf_w = 7'h01; exp_ovf_s = 7'h01;
    rd(0, 1, 15, "overflow_ev0");

    // clear, then clear colliding with an event
    clear = 1; tick(); clear = 0;
    exp_ovf_w = '0; exp_ovf_s = '0;
    rd(0, 0, 0, "clear_ev0");
    ev = 4'b0100;
    repeat (9) tick();
    ev = '0;
    rd(2, 9, 9, "ev2_count9");
    clear = 1; ev = 4'b0100; tick();
    clear = 0; ev = '0;
    rd(2, 0, 0, "clear_vs_event");
    rd(5, 0, 0, "clear_br_correct");

    // reset mid-operation discards in-flight predictions
    pred = 1; ev = 4'b0010; tick(); tick();
    rst = 1; pred = 0; tick();
    rst = 0; ev = '0; brv = 1; brt = 0; tick();
    brv = 0;
    rd(1, 0, 0, "midrst_ev1");
    rd(5, 1, 1, "midrst_correct");
    rd(6, 0, 0, "midrst_incorrect");

`ifdef PERF_SNAPSHOT_EN
    auto_snap = 1'b0;
    ev = 4'b0001; repeat (7) tick(); ev = '0;
    snap = 1; tick(); snap = 0;
    ev = 4'b0001; repeat (3) tick(); ev = '0;
    rd(0, 7, 7, "snap_first");
    snap = 1; tick(); snap = 0;
    rd(0, 10, 10, "snap_second");
`endif

    repeat (3) tick();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
